// File: rtl/serv_lsu.sv
// serv_lsu: load/store unit for the SERV core.
// Turns a W-bit-per-cycle serial operand stream into one Wishbone data access.
// Loaded data comes back as a serial stream of the same width.
//
// Parameters:
//   W          serial beat width (1, 2, 4 or 8); N = 32/W beats per word
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   i_start, i_we, i_signed,     request pulse plus op fields, all latched
//   i_word, i_half, i_lsb          when a request is accepted
//   i_rs2 / o_rd, o_rd_vld       serial store data in / serial load data out
//   o_busy, o_done, o_misalign   status
//   o_wb_*, i_wb_rdt, i_wb_ack   Wishbone data master port
// Optional feature:
//   define SERV_LSU_MISALIGN_EN to trap misaligned requests without a bus cycle.
//   When it is undefined, o_misalign is tied to 0.
module serv_lsu #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_we,
  input  logic         i_signed,
  input  logic         i_word,
  input  logic         i_half,
  input  logic [1:0]   i_lsb,
  input  logic [W-1:0] i_rs2,
  output logic [W-1:0] o_rd,
  output logic         o_rd_vld,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_misalign,
  output logic         o_wb_cyc,
  output logic         o_wb_we,
  output logic [3:0]   o_wb_sel,
  output logic [31:0]  o_wb_dat,
  input  logic [31:0]  i_wb_rdt,
  input  logic         i_wb_ack
);

  localparam int unsigned N  = 32 / W;
  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, SHIN, BUS, SHOUT} state_t;

  state_t        state;
  state_t        state_nxt;
  state_t        start_tgt;
  logic [CW-1:0] cnt;
  logic [31:0]   dat;
  logic          op_we;
  logic          op_signed;
  logic          op_word;
  logic          op_half;
  logic [1:0]    op_lsb;
  logic          done_q;
  logic          misalign_q;

  logic          last_beat;
  logic          shout_last;
  logic          start_ok;
  logic          mis_req;
  logic [31:0]   rdt_sh;
  logic [31:0]   rdt_ext;
  logic [3:0]    sel;

  assign last_beat  = (cnt == CW'(N - 1));
  assign shout_last = (state == SHOUT) && last_beat;
  // The final SHOUT beat doubles as an idle slot so a new request can issue
  // in the same cycle o_done is visible.
  assign start_ok   = i_start && ((state == IDLE) || shout_last);

`ifdef SERV_LSU_MISALIGN_EN
  assign mis_req = (i_word && (i_lsb != 2'd0)) || (i_half && i_lsb[0]);
`else
  assign mis_req = 1'b0;
`endif

  // Where an accepted request goes; misaligned requests bounce straight back.
  always_comb begin
    start_tgt = IDLE;
    if (!mis_req) start_tgt = i_we ? SHIN : BUS;
  end

  // Byte lanes for the latched access size and offset.
  always_comb begin
    sel = 4'(4'b0001 << op_lsb);
    if (op_word)      sel = 4'b1111;
    else if (op_half) sel = 4'(4'b0011 << op_lsb);
  end

  // Align read data to bit 0, then sign/zero extend from the access size.
  assign rdt_sh = i_wb_rdt >> {op_lsb, 3'b000};
  always_comb begin
    rdt_ext = {{24{op_signed & rdt_sh[7]}}, rdt_sh[7:0]};
    if (op_word)      rdt_ext = rdt_sh;
    else if (op_half) rdt_ext = {{16{op_signed & rdt_sh[15]}}, rdt_sh[15:0]};
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = start_tgt;
      SHIN:    if (last_beat) state_nxt = BUS;
      BUS:     if (i_wb_ack) state_nxt = op_we ? IDLE : SHOUT;
      SHOUT:   if (last_beat) state_nxt = i_start ? start_tgt : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state and datapath.
  always_comb begin
    o_busy     = 1'b0;
    o_done     = done_q | shout_last;
    o_misalign = misalign_q;
    o_rd       = '0;
    o_rd_vld   = 1'b0;
    o_wb_cyc   = 1'b0;
    o_wb_we    = 1'b0;
    o_wb_sel   = 4'b0000;
    o_wb_dat   = 32'h0;
    case (state)
      SHIN: o_busy = 1'b1;
      BUS: begin
        o_busy   = 1'b1;
        o_wb_cyc = 1'b1;
        o_wb_we  = op_we;
        o_wb_sel = sel;
        o_wb_dat = dat << {op_lsb, 3'b000};
      end
      SHOUT: begin
        o_busy   = !last_beat;
        o_rd_vld = 1'b1;
        o_rd     = dat[W-1:0];
      end
      default: ;
    endcase
  end

  // Beat counter restarts on every state entry and on each accepted request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (start_ok || (state_nxt != state)) begin
      cnt <= '0;
    end else if ((state == SHIN) || (state == SHOUT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Op latch, data shift register and completion pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dat        <= 32'h0;
      op_we      <= 1'b0;
      op_signed  <= 1'b0;
      op_word    <= 1'b0;
      op_half    <= 1'b0;
      op_lsb     <= 2'd0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      if (start_ok) begin
        op_we      <= i_we;
        op_signed  <= i_signed;
        op_word    <= i_word;
        op_half    <= i_half;
        op_lsb     <= i_lsb;
        done_q     <= mis_req;
        misalign_q <= mis_req;
      end
      case (state)
        // Beats enter at the top so beat k ends up in bits [kW+W-1:kW].
        SHIN:  dat <= {i_rs2, dat[31:W]};
        BUS: begin
          if (i_wb_ack) begin
            if (op_we) done_q <= 1'b1;
            else       dat    <= rdt_ext;
          end
        end
        SHOUT: dat <= dat >> W;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_lsu.sv
// Bench for serv_lsu at W=4: table of accesses plus hand-written sequences for
// back-to-back issue, ignored start/ack, misaligned requests and mid-access reset.
module tb_serv_lsu;

  localparam int unsigned W = 4;
  localparam int unsigned N = 32 / W;
`ifdef SERV_LSU_MISALIGN_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic        sgn;
    logic        word;
    logic        half;
    logic [1:0]  lsb;
    logic [31:0] data;   // store value, or read data returned for a load
    int          delay;  // BUS cycles before ack
    logic [31:0] res;    // expected load result
    logic [3:0]  sel;
    logic [31:0] dat;    // expected o_wb_dat for stores
  } vec_t;

  typedef struct {
    logic        we;
    logic        mis;
    logic [31:0] res;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] rdt;
    int          delay;
    int          start;
    int          lat;
  } exp_t;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_start = 1'b0;
  logic         i_we = 1'b0;
  logic         i_signed = 1'b0;
  logic         i_word = 1'b0;
  logic         i_half = 1'b0;
  logic [1:0]   i_lsb = 2'd0;
  logic [W-1:0] i_rs2 = '0;
  logic [W-1:0] o_rd;
  logic         o_rd_vld;
  logic         o_busy;
  logic         o_done;
  logic         o_misalign;
  logic         o_wb_cyc;
  logic         o_wb_we;
  logic [3:0]   o_wb_sel;
  logic [31:0]  o_wb_dat;
  logic [31:0]  i_wb_rdt = 32'h0;
  logic         i_wb_ack;
  logic         resp_ack = 1'b0;
  logic         stray_ack = 1'b0;

  assign i_wb_ack = resp_ack | stray_ack;

  int          total = 0;
  int          bad = 0;
  int          cyc_cnt = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  vec_t        tbl[14];
  vec_t        mtbl[3];
  vec_t        hv;
  logic [31:0] rd_acc = 32'h0;
  int          rd_beats = 0;
  int          wait_cnt = 0;

  serv_lsu #(.W(W)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_we       (i_we),
    .i_signed   (i_signed),
    .i_word     (i_word),
    .i_half     (i_half),
    .i_lsb      (i_lsb),
    .i_rs2      (i_rs2),
    .o_rd       (o_rd),
    .o_rd_vld   (o_rd_vld),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_misalign (o_misalign),
    .o_wb_cyc   (o_wb_cyc),
    .o_wb_we    (o_wb_we),
    .o_wb_sel   (o_wb_sel),
    .o_wb_dat   (o_wb_dat),
    .i_wb_rdt   (i_wb_rdt),
    .i_wb_ack   (i_wb_ack)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic sgn, input logic word,
                              input logic half, input logic [1:0] lsb,
                              input logic [31:0] data, input int delay,
                              input logic [31:0] res, input logic [3:0] sel,
                              input logic [31:0] dat);
    vec_t v;
    v.we = we; v.sgn = sgn; v.word = word; v.half = half; v.lsb = lsb;
    v.data = data; v.delay = delay; v.res = res; v.sel = sel; v.dat = dat;
    return v;
  endfunction

  // Drive one request starting now; expected outcome goes on the scoreboard.
  task automatic issue(input vec_t v, input logic mis);
    exp_t        e;
    logic [31:0] d;
    e.we = v.we; e.mis = mis; e.res = v.res; e.sel = v.sel; e.dat = v.dat;
    e.rdt = v.data; e.delay = v.delay; e.start = cyc_cnt;
    if (mis)       e.lat = 1;
    else if (v.we) e.lat = int'(N) + 2 + v.delay;
    else           e.lat = int'(N) + 1 + v.delay;
    exp_q.push_back(e);
    i_start = 1'b1; i_we = v.we; i_signed = v.sgn; i_word = v.word;
    i_half = v.half; i_lsb = v.lsb;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_we = ~v.we; i_signed = ~v.sgn; i_word = ~v.word;
    i_half = ~v.half; i_lsb = ~v.lsb;
    if (v.we) begin
      d = v.data;
      for (int k = 0; k < int'(N); k++) begin
        i_rs2 = d[k*W +: W];
        @(posedge i_clk); #1;
      end
      i_rs2 = '0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0) && (t < 500)) begin
      @(negedge i_clk);
      t++;
    end
    check("pending_ops", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    do begin
      @(negedge i_clk);
      t++;
    end while (!o_done && (t < 200));
    check("done_seen", 32'(o_done), 32'd1);
  endtask

  // Wishbone slave model and output monitor / scoreboard.
  always @(negedge i_clk) begin
    if (i_rst) begin
      exp_q.delete();
      wait_cnt = 0;
      resp_ack = 1'b0;
      rd_acc   = 32'h0;
      rd_beats = 0;
    end else begin
      if (o_rd_vld) begin
        rd_acc = rd_acc | (32'(o_rd) << (rd_beats * int'(W)));
        rd_beats++;
      end
      if (o_wb_cyc) begin
        if (exp_q.size() == 0) begin
          check("stray_cyc", 32'(o_wb_cyc), 32'd0);
        end else begin
          wait_cnt++;
          if (exp_q[0].mis) check("misaligned_cyc", 32'(o_wb_cyc), 32'd0);
          if (wait_cnt == exp_q[0].delay + 1) begin
            resp_ack = 1'b1;
            i_wb_rdt = exp_q[0].rdt;
            check("wb_sel", 32'(o_wb_sel), 32'(exp_q[0].sel));
            check("wb_we", 32'(o_wb_we), 32'(exp_q[0].we));
            if (exp_q[0].we) check("wb_dat", o_wb_dat, exp_q[0].dat);
          end else begin
            resp_ack = 1'b0;
          end
        end
      end else begin
        wait_cnt = 0;
        resp_ack = 1'b0;
      end
      if (o_done) begin
        if (exp_q.size() == 0) begin
          check("stray_done", 32'(o_done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("latency", 32'(cyc_cnt - mon_e.start), 32'(mon_e.lat));
          check("busy_at_done", 32'(o_busy), 32'd0);
          check("misalign_flag", 32'(o_misalign), 32'(mon_e.mis));
          if (!mon_e.we && !mon_e.mis) begin
            check("rd_vld_at_done", 32'(o_rd_vld), 32'd1);
            check("load_beats", 32'(rd_beats), 32'(N));
            check("load_data", rd_acc, mon_e.res);
          end else begin
            check("rd_vld_no_load", 32'(o_rd_vld), 32'd0);
          end
        end
        rd_acc   = 32'h0;
        rd_beats = 0;
      end else if (o_misalign) begin
        check("misalign_without_done", 32'(o_misalign), 32'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    //            we sgn wd hf lsb   data          dly res            sel      dat
    tbl[0]  = mk(1, 0, 1, 0, 2'd0, 32'hDEADBEEF, 3, 32'h0,        4'b1111, 32'hDEADBEEF);
    tbl[1]  = mk(0, 1, 0, 0, 2'd3, 32'h80123456, 0, 32'hFFFFFF80, 4'b1000, 32'h0);
    tbl[2]  = mk(0, 0, 0, 1, 2'd2, 32'h8001FFFF, 1, 32'h00008001, 4'b1100, 32'h0);
    tbl[3]  = mk(1, 0, 0, 0, 2'd1, 32'h000000A5, 0, 32'h0,        4'b0010, 32'h0000A500);
    tbl[4]  = mk(1, 0, 0, 0, 2'd1, 32'h123456A5, 2, 32'h0,        4'b0010, 32'h3456A500);
    tbl[5]  = mk(0, 1, 0, 1, 2'd0, 32'h1234F00D, 0, 32'hFFFFF00D, 4'b0011, 32'h0);
    tbl[6]  = mk(0, 0, 0, 0, 2'd1, 32'h00008F00, 4, 32'h0000008F, 4'b0010, 32'h0);
    tbl[7]  = mk(0, 0, 1, 0, 2'd0, 32'hCAFEBABE, 2, 32'hCAFEBABE, 4'b1111, 32'h0);
    tbl[8]  = mk(0, 1, 0, 0, 2'd0, 32'h0000007F, 0, 32'h0000007F, 4'b0001, 32'h0);
    tbl[9]  = mk(1, 0, 0, 1, 2'd2, 32'hBEEF1234, 1, 32'h0,        4'b1100, 32'h12340000);
    tbl[10] = mk(0, 1, 1, 0, 2'd0, 32'h80000001, 0, 32'h80000001, 4'b1111, 32'h0);
    tbl[11] = mk(0, 1, 0, 1, 2'd2, 32'h7FFF0000, 0, 32'h00007FFF, 4'b1100, 32'h0);
    tbl[12] = mk(1, 0, 0, 0, 2'd3, 32'h000000C3, 0, 32'h0,        4'b1000, 32'hC3000000);
    tbl[13] = mk(0, 0, 0, 0, 2'd2, 32'h00FF0000, 1, 32'h000000FF, 4'b0100, 32'h0);
    // Misaligned requests; expectations apply when they run as normal accesses.
    mtbl[0] = mk(0, 0, 1, 0, 2'd2, 32'h11223344, 0, 32'h00001122, 4'b1111, 32'h0);
    mtbl[1] = mk(1, 0, 0, 1, 2'd3, 32'h0000BEEF, 0, 32'h0,        4'b1000, 32'hEF000000);
    mtbl[2] = mk(0, 1, 0, 1, 2'd1, 32'hAABBCCDD, 1, 32'hFFFFBBCC, 4'b0110, 32'h0);

    // Reset state.
    repeat (2) @(negedge i_clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_rd_vld", 32'(o_rd_vld), 32'd0);
    check("rst_misalign", 32'(o_misalign), 32'd0);
    check("rst_wb_cyc", 32'(o_wb_cyc), 32'd0);
    check("rst_wb_we", 32'(o_wb_we), 32'd0);
    check("rst_rd", 32'(o_rd), 32'd0);
    check("rst_wb_sel", 32'(o_wb_sel), 32'd0);
    check("rst_wb_dat", o_wb_dat, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Table of single accesses.
    for (int i = 0; i < 14; i++) begin
      @(posedge i_clk); #1;
      issue(tbl[i], 1'b0);
      wait_idle();
    end

    // Misaligned requests.
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      issue(mtbl[i], MIS_EN);
      wait_idle();
    end

    // Back-to-back: new request in the very cycle o_done is visible.
    @(posedge i_clk); #1;
    issue(tbl[7], 1'b0);
    wait_done();
    issue(tbl[3], 1'b0);
    wait_done();
    issue(tbl[1], 1'b0);
    wait_idle();

    // i_start while the bus cycle is pending must be ignored.
    hv = tbl[7];
    hv.delay = 5;
    @(posedge i_clk); #1;
    issue(hv, 1'b0);
    @(posedge i_clk); #1;
    i_start = 1'b1; i_we = 1'b1; i_word = 1'b0; i_half = 1'b0; i_lsb = 2'd3;
    @(negedge i_clk);
    check("busy_in_bus", 32'(o_busy), 32'd1);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    wait_idle();
    repeat (N + 2) @(negedge i_clk);
    check("busy_after_ignored_start", 32'(o_busy), 32'd0);

    // Ack outside BUS (idle and during SHIN) must be ignored.
    @(posedge i_clk); #1;
    stray_ack = 1'b1;
    @(posedge i_clk); #1;
    issue(tbl[9], 1'b0);
    stray_ack = 1'b0;
    wait_idle();

    // Async reset in the middle of a load bus cycle.
    hv = tbl[2];
    hv.delay = 40;
    @(posedge i_clk); #1;
    issue(hv, 1'b0);
    begin
      int t;
      t = 0;
      do begin
        @(negedge i_clk);
        t++;
      end while (!o_wb_cyc && (t < 20));
    end
    check("cyc_before_reset", 32'(o_wb_cyc), 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check("reset_cyc_async", 32'(o_wb_cyc), 32'd0);
    check("reset_busy_async", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_rd_vld", 32'(o_rd_vld), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    issue(tbl[1], 1'b0);
    wait_idle();
    @(posedge i_clk); #1;
    issue(tbl[4], 1'b0);
    wait_idle();

    repeat (4) @(negedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
